alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter NREGS, default 4, meaning number of 8-bit registers in the register file (fixed at 4 by the 2-bit register fields).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr  input  8  instruction: [7:5] opcode, [3:2] rd, [1:0] rs, [4] reserved (ignored).
REQ-006 instr_ready  output  1  sequencer will accept instr this cycle.
REQ-007 ld_en  input  1  direct register load request.
REQ-008 ld_addr  input  2  load target register.
REQ-009 ld_data  input  8  load value.
REQ-010 rd_addr  input  2  observation read address.
REQ-011 rd_data  output  8  combinational read of reg[rd_addr].
REQ-012 alu_op1, alu_op2  output  8 each  operands driven to the ALU.
REQ-013 alu_sel  output  3  ALU operation select.
REQ-014 alu_out  input  8  ALU result.
REQ-015 alu_co  input  1  ALU carry/flag output.
REQ-016 carry  output  1  registered carry flag.
REQ-017 done  output  1  one-cycle pulse when an instruction retires.

Function
REQ-018 The FSM SHALL have states IDLE, DECODE, EXEC, WB; IDLE->DECODE on accept, DECODE->EXEC, EXEC->WB, WB->IDLE, all unconditional except the first.
REQ-019 instr_ready SHALL equal (state==IDLE) AND NOT ld_en; accept = instr_valid AND instr_ready, capturing instr into an instruction register.
REQ-020 In DECODE the sequencer SHALL register alu_sel<=opcode, alu_op1<=reg[rd], alu_op2<=reg[rs]; these outputs hold until the next DECODE.
REQ-021 In EXEC the sequencer SHALL capture alu_out and alu_co into result/flag holding registers (ALU treated as combinational).
REQ-022 In WB the sequencer SHALL write reg[rd]<=result, carry<=flag, and assert done for exactly that cycle.
REQ-023 Every opcode 000-111 SHALL write back; 100, 101, 111 thus copy reg[rd] to itself and clear carry via alu_co; div2 (011) and comp2s (110) ignore op2.
REQ-024 Latency: done SHALL assert in the 3rd cycle after the accept edge; throughput one instruction per 4 cycles.
REQ-025 A load SHALL be performed (reg[ld_addr]<=ld_data) only when state==IDLE and ld_en=1; ld_en in any other state SHALL be ignored, not queued.
REQ-026 Simultaneous ld_en and instr_valid in IDLE: load wins, instruction not accepted that cycle.
REQ-027 rd==rs SHALL be legal; both operands equal the pre-instruction value of that register.
REQ-028 A load in the IDLE cycle directly after WB SHALL see the written-back value for non-target registers and overwrite the target.
REQ-029 All arithmetic is 8-bit; no width extension inside the sequencer; carry sourced only from alu_co.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, all registers and instruction register to 0x00, alu_op1/op2=0x00, alu_sel=3'b000, carry=0, done=0.
REQ-031 Reset asserted mid-instruction SHALL abort it with no writeback and no done pulse; after release instr_ready=1 on the first cycle with ld_en=0.

Structure
REQ-032 Opcode constants (ADD, ASHL, XNOR, DIV2, PASS4, PASS5, COMP2S, PASS7) and FSM state encodings SHALL live in a shared package used by the ALU and the sequencer.
REQ-033 The register file SHALL be a separate sub-module, alu_regfile (one write port, three combinational read ports).

Verification
REQ-034 Load R0=0x05, R1=0x03; ADD rd=0 rs=1 -> R0=0x08, carry=0, done 3 cycles after accept.
REQ-035 Load R2=0xFF, R3=0x01; ADD rd=2 rs=3 -> R2=0x00, carry=1.
REQ-036 Load R1=0x05; COMP2S rd=1 -> R1=0xFB, carry=0; DIV2 on R1=0x07 -> value per ALU, carry=alu_co.
REQ-037 ld_en=1 with ld_addr=0, ld_data=0xAA held during DECODE/EXEC -> R0 unchanged; same cycle in IDLE with instr_valid -> load done, instr_ready=0.
REQ-038 rst_n pulsed low in EXEC of ADD -> no done, all registers 0x00, carry=0, next instruction accepted normally.
REQ-039 Back-to-back instr_valid held high -> accepts exactly every 4 cycles, one done per accept.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer and the ALU it drives.
// Contents:
//   opcode_t / opcode constants  - 3-bit ALU operation select values
//   state_t                      - sequencer FSM state encoding
//   field helpers                - extract rd / rs / opcode from an instruction
package alu_sequencer_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t ADD    = 3'b000;
    localparam opcode_t ASHL   = 3'b001;
    localparam opcode_t XNOR   = 3'b010;
    localparam opcode_t DIV2   = 3'b011;
    localparam opcode_t PASS4  = 3'b100;
    localparam opcode_t PASS5  = 3'b101;
    localparam opcode_t COMP2S = 3'b110;
    localparam opcode_t PASS7  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DECODE = 2'b01,
        EXEC   = 2'b10,
        WB     = 2'b11
    } state_t;

    // Instruction layout: [7:5] opcode, [4] reserved, [3:2] rd, [1:0] rs.
    function automatic opcode_t instr_opcode(input logic [7:0] instr);
        return instr[7:5];
    endfunction

    function automatic logic [1:0] instr_rd(input logic [7:0] instr);
        return instr[3:2];
    endfunction

    function automatic logic [1:0] instr_rs(input logic [7:0] instr);
        return instr[1:0];
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake plus the ALU operand/result bus.
// Signals:
//   instr_valid / instr / instr_ready - instruction offer from the environment
//   alu_op1 / alu_op2 / alu_sel       - operands and operation driven to the ALU
//   alu_out / alu_co                  - combinational ALU result and carry/flag
// Handshake: an instruction transfers on a rising clk edge where instr_valid
// and instr_ready are both 1. instr_ready does not depend on instr_valid; the
// offerer keeps instr stable while instr_valid is high and not yet accepted.
// Modports:
//   slave  - the sequencer side
//   master - the environment side (instruction source and the ALU)
interface alu_sequencer_if;
    import alu_sequencer_pkg::*;

    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic [7:0] alu_op1;
    logic [7:0] alu_op2;
    opcode_t    alu_sel;
    logic [7:0] alu_out;
    logic       alu_co;

    modport slave (
        input  instr_valid, instr, alu_out, alu_co,
        output instr_ready, alu_op1, alu_op2, alu_sel
    );

    modport master (
        output instr_valid, instr, alu_out, alu_co,
        input  instr_ready, alu_op1, alu_op2, alu_sel
    );

endinterface

// File: rtl/alu_regfile.sv
// 8-bit register file: one synchronous write port, three combinational reads.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset (clears all regs)
//   we, waddr, wdata  - write port
//   raddr_a / rdata_a - read port A (first ALU operand)
//   raddr_b / rdata_b - read port B (second ALU operand)
//   raddr_c / rdata_c - read port C (observation)
module alu_regfile #(
    parameter int NREGS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [7:0] wdata,
    input  logic [1:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [1:0] raddr_b,
    output logic [7:0] rdata_b,
    input  logic [1:0] raddr_c,
    output logic [7:0] rdata_c
);

    logic [7:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_c = regs[raddr_c];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer around an external combinational ALU.
// An accepted instruction walks IDLE -> DECODE -> EXEC -> WB -> IDLE:
// DECODE latches operands and select, EXEC latches the ALU result and flag,
// WB writes the result back, updates carry and pulses done.
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   bus (slave)               - instruction handshake and ALU bus
//   ld_en, ld_addr, ld_data   - direct register load, honoured only in IDLE
//   rd_addr, rd_data          - combinational register observation
//   carry                     - registered carry flag
//   done                      - one-cycle pulse in the WB cycle
//   fsm_state                 - current FSM state, for observation
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int NREGS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.slave  bus,
    input  logic            ld_en,
    input  logic [1:0]      ld_addr,
    input  logic [7:0]      ld_data,
    input  logic [1:0]      rd_addr,
    output logic [7:0]      rd_data,
    output logic            carry,
    output logic            done,
    output state_t          fsm_state
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] ir;
    logic [7:0] op1_q;
    logic [7:0] op2_q;
    opcode_t    sel_q;
    logic [7:0] result_q;
    logic       flag_q;
    logic       carry_q;
    logic       ready;
    logic       accept;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;
    logic       unused_reserved;

    // The reserved instruction bit is captured but has no effect.
    assign unused_reserved = ir[4];

    alu_regfile #(.NREGS(NREGS)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (instr_rd(ir)),
        .rdata_a (rdata_a),
        .raddr_b (instr_rs(ir)),
        .rdata_b (rdata_b),
        .raddr_c (rd_addr),
        .rdata_c (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ir       <= 8'h00;
            op1_q    <= 8'h00;
            op2_q    <= 8'h00;
            sel_q    <= ADD;
            result_q <= 8'h00;
            flag_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ir <= bus.instr;
            end
            // Operands and select stay put until the next DECODE so the
            // ALU sees stable inputs for the whole EXEC cycle.
            if (state == DECODE) begin
                sel_q <= instr_opcode(ir);
                op1_q <= rdata_a;
                op2_q <= rdata_b;
            end
            if (state == EXEC) begin
                result_q <= bus.alu_out;
                flag_q   <= bus.alu_co;
            end
            if (state == WB) begin
                carry_q <= flag_q;
            end
        end
    end

    // Next state, handshake and the shared write port. Loads and writeback
    // live in different states, so the write port never has two sources.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        we        = 1'b0;
        waddr     = ld_addr;
        wdata     = ld_data;
        done      = 1'b0;
        case (state)
            IDLE: begin
                // A load request blocks acceptance: the load wins.
                ready  = !ld_en;
                accept = bus.instr_valid && !ld_en;
                we     = ld_en;
                if (accept) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: state_nxt = EXEC;
            EXEC:   state_nxt = WB;
            WB: begin
                we        = 1'b1;
                waddr     = instr_rd(ir);
                wdata     = result_q;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.instr_ready = ready;
    assign bus.alu_op1     = op1_q;
    assign bus.alu_op2     = op2_q;
    assign bus.alu_sel     = sel_q;
    assign carry           = carry_q;
    assign fsm_state       = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural combinational ALU.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_en = 1'b0;
    logic [1:0] ld_addr = 2'd0;
    logic [7:0] ld_data = 8'h00;
    logic [1:0] rd_addr = 2'd0;
    logic [7:0] rd_data;
    logic       carry;
    logic       done;
    state_t     fsm_state;

    int vectors = 0;
    int miscompares = 0;

    alu_sequencer_if bus ();

    alu_sequencer #(.NREGS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .carry     (carry),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- ALU model ----------------
    always_comb begin
        bus.alu_out = bus.alu_op1;
        bus.alu_co  = 1'b0;
        case (bus.alu_sel)
            ADD:    {bus.alu_co, bus.alu_out} = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
            ASHL:   begin bus.alu_out = {bus.alu_op1[6:0], 1'b0}; bus.alu_co = bus.alu_op1[7]; end
            XNOR:   bus.alu_out = ~(bus.alu_op1 ^ bus.alu_op2);
            DIV2:   begin bus.alu_out = {1'b0, bus.alu_op1[7:1]}; bus.alu_co = bus.alu_op1[0]; end
            COMP2S: bus.alu_out = ~bus.alu_op1 + 8'd1;
            default: bus.alu_out = bus.alu_op1;
        endcase
    end

    // ---------------- drivers ----------------
    task automatic do_load(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Offers one instruction, returns cycles from accept edge to done
    // (10 on timeout), and ends at the IDLE negedge after writeback.
    task automatic issue(input opcode_t op, input logic [1:0] rd, input logic [1:0] rs,
                         output int lat);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = {op, 1'b0, rd, rs};
        @(negedge clk);
        bus.instr_valid = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    task automatic peek(input logic [1:0] a, output logic [7:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [7:0] d;
        #2;
        vectors++;
        if (fsm_state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", fsm_state, IDLE); end
        vectors++;
        if (carry !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_flags: carry=%b done=%b want 0 0", carry, done); end
        vectors++;
        if (bus.alu_op1 !== 8'h00 || bus.alu_op2 !== 8'h00 || bus.alu_sel !== 3'b000) begin
            miscompares++; $display("FAIL reset_alu_bus: op1=%h op2=%h sel=%b want 00 00 000", bus.alu_op1, bus.alu_op2, bus.alu_sel);
        end
        vectors++;
        if (bus.instr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.instr_ready); end
        for (int i = 0; i < 4; i++) begin
            peek(i[1:0], d);
            vectors++;
            if (d !== 8'h00) begin miscompares++; $display("FAIL reset_reg%0d: got %h want 00", i, d); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        int lat; logic [7:0] d;
        do_load(2'd0, 8'h05);
        do_load(2'd1, 8'h03);
        issue(ADD, 2'd0, 2'd1, lat);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL add_latency: got %0d want 3", lat); end
        peek(2'd0, d);
        vectors++;
        if (d !== 8'h08) begin miscompares++; $display("FAIL add_r0: got %h want 08", d); end
        vectors++;
        if (carry !== 1'b0) begin miscompares++; $display("FAIL add_carry: got %b want 0", carry); end
        vectors++;
        if (bus.alu_op1 !== 8'h05 || bus.alu_op2 !== 8'h03 || bus.alu_sel !== ADD) begin
            miscompares++; $display("FAIL add_operands_held: op1=%h op2=%h sel=%b want 05 03 000", bus.alu_op1, bus.alu_op2, bus.alu_sel);
        end
    endtask

    task automatic test_add_carry;
        int lat; logic [7:0] d;
        do_load(2'd2, 8'hFF);
        do_load(2'd3, 8'h01);
        issue(ADD, 2'd2, 2'd3, lat);
        peek(2'd2, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL addc_r2: got %h want 00", d); end
        vectors++;
        if (carry !== 1'b1) begin miscompares++; $display("FAIL addc_carry: got %b want 1", carry); end
        peek(2'd3, d);
        vectors++;
        if (d !== 8'h01) begin miscompares++; $display("FAIL addc_r3: got %h want 01", d); end
    endtask

    task automatic test_ops;
        int lat; logic [7:0] d;
        do_load(2'd1, 8'h05);
        issue(COMP2S, 2'd1, 2'd0, lat);
        peek(2'd1, d);
        vectors++;
        if (d !== 8'hFB || carry !== 1'b0) begin miscompares++; $display("FAIL comp2s: got %h c=%b want FB c=0", d, carry); end
        do_load(2'd1, 8'h07);
        issue(DIV2, 2'd1, 2'd2, lat);
        peek(2'd1, d);
        vectors++;
        if (d !== 8'h03 || carry !== 1'b1) begin miscompares++; $display("FAIL div2: got %h c=%b want 03 c=1", d, carry); end
        do_load(2'd2, 8'h81);
        issue(ASHL, 2'd2, 2'd2, lat);
        peek(2'd2, d);
        vectors++;
        if (d !== 8'h02 || carry !== 1'b1) begin miscompares++; $display("FAIL ashl: got %h c=%b want 02 c=1", d, carry); end
        do_load(2'd0, 8'hF0);
        do_load(2'd1, 8'h3C);
        issue(XNOR, 2'd0, 2'd1, lat);
        peek(2'd0, d);
        vectors++;
        if (d !== 8'h33 || carry !== 1'b0) begin miscompares++; $display("FAIL xnor: got %h c=%b want 33 c=0", d, carry); end
        // rd == rs: both operands are the old 0x80
        do_load(2'd3, 8'h80);
        issue(ADD, 2'd3, 2'd3, lat);
        peek(2'd3, d);
        vectors++;
        if (d !== 8'h00 || carry !== 1'b1) begin miscompares++; $display("FAIL add_same_reg: got %h c=%b want 00 c=1", d, carry); end
        issue(PASS5, 2'd0, 2'd3, lat);
        peek(2'd0, d);
        vectors++;
        if (d !== 8'h33 || carry !== 1'b0) begin miscompares++; $display("FAIL pass5: got %h c=%b want 33 c=0", d, carry); end
    endtask

    task automatic test_load_ignored;
        int cyc; logic [7:0] d;
        do_load(2'd0, 8'h11);
        do_load(2'd1, 8'h01);
        @(negedge clk);
        bus.instr_valid = 1'b1; bus.instr = {ADD, 1'b0, 2'd0, 2'd1};
        @(negedge clk);                       // DECODE
        bus.instr_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'hAA;
        #1;
        vectors++;
        if (bus.instr_ready !== 1'b0) begin miscompares++; $display("FAIL busy_ready: got %b want 0", bus.instr_ready); end
        @(negedge clk);                       // EXEC
        @(negedge clk);                       // WB
        ld_en = 1'b0;
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL busy_done: got %b want 1", done); end
        @(negedge clk);                       // IDLE
        peek(2'd0, d);
        vectors++;
        if (d !== 8'h12) begin miscompares++; $display("FAIL busy_load_ignored: got %h want 12", d); end
        // load and instruction offered together: load wins
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'hAA;
        bus.instr_valid = 1'b1; bus.instr = {ADD, 1'b0, 2'd0, 2'd1};
        #1;
        vectors++;
        if (bus.instr_ready !== 1'b0) begin miscompares++; $display("FAIL collide_ready: got %b want 0", bus.instr_ready); end
        @(negedge clk);
        ld_en = 1'b0;
        peek(2'd0, d);
        vectors++;
        if (d !== 8'hAA || fsm_state !== IDLE) begin miscompares++; $display("FAIL collide_load: r0=%h state=%0d want AA 0", d, fsm_state); end
        @(negedge clk);                       // accepted on the edge just passed
        bus.instr_valid = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        vectors++;
        if (cyc !== 3) begin miscompares++; $display("FAIL collide_latency: got %0d want 3", cyc); end
        @(negedge clk);
        peek(2'd0, d);
        vectors++;
        if (d !== 8'hAB) begin miscompares++; $display("FAIL collide_result: got %h want AB", d); end
    endtask

    task automatic test_load_after_wb;
        int lat; logic [7:0] d;
        do_load(2'd0, 8'h10);
        do_load(2'd1, 8'h20);
        issue(ADD, 2'd0, 2'd1, lat);          // ends in the IDLE cycle after WB
        peek(2'd0, d);
        vectors++;
        if (d !== 8'h30) begin miscompares++; $display("FAIL wb_value: got %h want 30", d); end
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h5A;
        @(negedge clk);
        ld_en = 1'b0;
        peek(2'd0, d);
        vectors++;
        if (d !== 8'h5A) begin miscompares++; $display("FAIL load_after_wb_target: got %h want 5A", d); end
        peek(2'd1, d);
        vectors++;
        if (d !== 8'h20) begin miscompares++; $display("FAIL load_after_wb_other: got %h want 20", d); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [7:0] d;
        do_load(2'd0, 8'hFF);
        do_load(2'd1, 8'h02);
        issue(ADD, 2'd0, 2'd1, lat);          // r0 = 01, carry = 1
        vectors++;
        if (carry !== 1'b1) begin miscompares++; $display("FAIL pre_reset_carry: got %b want 1", carry); end
        @(negedge clk);
        bus.instr_valid = 1'b1; bus.instr = {ADD, 1'b0, 2'd0, 2'd1};
        @(negedge clk);                       // DECODE
        bus.instr_valid = 1'b0;
        @(negedge clk);                       // EXEC
        vectors++;
        if (fsm_state !== EXEC) begin miscompares++; $display("FAIL mid_state: got %0d want %0d", fsm_state, EXEC); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (fsm_state !== IDLE || done !== 1'b0 || carry !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset: state=%0d done=%b carry=%b want 0 0 0", fsm_state, done, carry);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL mid_no_done: got %b want 0", done); end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.instr_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %b want 1", bus.instr_ready); end
        for (int i = 0; i < 4; i++) begin
            peek(i[1:0], d);
            vectors++;
            if (d !== 8'h00) begin miscompares++; $display("FAIL post_reset_reg%0d: got %h want 00", i, d); end
        end
        do_load(2'd0, 8'h04);
        do_load(2'd1, 8'h04);
        issue(ADD, 2'd0, 2'd1, lat);
        peek(2'd0, d);
        vectors++;
        if (lat !== 3 || d !== 8'h08) begin miscompares++; $display("FAIL post_reset_add: lat=%0d r0=%h want 3 08", lat, d); end
    endtask

    task automatic test_back_to_back;
        int acc_q[$];
        int done_q[$];
        logic [7:0] d;
        do_load(2'd0, 8'h00);
        do_load(2'd1, 8'h01);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = {ADD, 1'b1, 2'd0, 2'd1};  // reserved bit set, must be ignored
        for (int i = 0; i < 16; i++) begin
            #1;
            if (bus.instr_ready === 1'b1) acc_q.push_back(i);
            if (done === 1'b1) done_q.push_back(i);
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        vectors++;
        if (acc_q.size() != 4) begin miscompares++; $display("FAIL b2b_accepts: got %0d want 4", acc_q.size()); end
        vectors++;
        if (done_q.size() != 4) begin miscompares++; $display("FAIL b2b_dones: got %0d want 4", done_q.size()); end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= acc_q.size() || acc_q[k] != 4 * k) begin
                miscompares++; $display("FAIL b2b_accept%0d: got %0d want %0d", k, (k < acc_q.size()) ? acc_q[k] : -1, 4 * k);
            end
            vectors++;
            if (k >= done_q.size() || done_q[k] != 4 * k + 3) begin
                miscompares++; $display("FAIL b2b_done%0d: got %0d want %0d", k, (k < done_q.size()) ? done_q[k] : -1, 4 * k + 3);
            end
        end
        peek(2'd0, d);
        vectors++;
        if (d !== 8'h04) begin miscompares++; $display("FAIL b2b_result: got %h want 04", d); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.instr_valid = 1'b0;
        bus.instr = 8'h00;
        test_reset();
        test_add();
        test_add_carry();
        test_ops();
        test_load_ignored();
        test_load_after_wb();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
